ab_4_bit: RTL and testbench
===========================

# ab_4_bit

Registered 2-bit magnitude comparator driven by four single-bit inputs. Input bits are packed as A = {a,b} and B = {c,d}, compared under a selectable relation, and the result is registered to output `s`. It sits in the Guide 2 combinational-logic practice chain as a clocked evaluator. It can be exercised exhaustively by sweeping all 16 input codes, with `a` as the MSB of the 4-bit code.

## Interface
Parameters:
- `CNT_W`, default 8: width of the optional true-result counter.

Ports (clock and reset first):
- Reset is asynchronous and active-low; the block uses one clock.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a`  in  1  A[1], MSB of operand A and MSB of the 4-bit input code.
- `b`  in  1  A[0].
- `c`  in  1  B[1].
- `d`  in  1  B[0], LSB of the input code.
- `mode`  in  2  relation select: 00 = A>B, 01 = A==B, 10 = A<B, 11 = A>=B.
- `s`  out  1  registered comparison result.
- `s_chg`  out  1  one-cycle pulse when `s` changes value.
- `true_cnt`  out  CNT_W  saturating count of cycles with `s`=1 (only when the feature is enabled).

## Operation
- Comparison is unsigned: A = 2·a + b, B = 2·c + d, so each operand is 0..3.
- The relation selected by `mode` is evaluated combinationally on the current inputs:
  - 00: A>B
  - 01: A==B
  - 10: A<B
  - 11: A>=B
- The result is captured into `s` at every rising `clk` edge.
- `s_chg` registers as (next `s` XOR current `s`). It is high for exactly one cycle, the cycle in which the new `s` value is first visible.
- `true_cnt`:
  - Increments by 1 on each rising edge at which the new `s` value is 1.
  - Saturates at 2^CNT_W−1; it never wraps.
- X or Z on any input must not be resolved optimistically. Synthesizable RTL only, with no latches.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge n appear on `s` after edge n; `s` is constant between edges.
- Inputs may change at any time away from the setup/hold window of the rising edge. In the standard stimulus, inputs change on falling edges.
- Reset:
  - Asserting `rst_n` low immediately clears `s`=0, `s_chg`=0 and `true_cnt`=0, independent of `clk`.
  - While `rst_n` is low, outputs hold 0.
  - The first capture occurs at the first rising edge after `rst_n` goes high.
  - The first `s` value after reset does not raise `s_chg` if it is 0. It raises `s_chg` if it is 1, because the comparison is against the reset value 0.
- A `mode` change takes effect at the next rising edge, with the same 1-cycle latency as data.
- When the counter is saturated and `s`=1, the count holds. When `s`=0, the count holds.

## Configuration
- Macro: `AB_4_BIT_TRUE_CNT_EN`.
- Defined:
  - The `true_cnt` port and its counter logic are present, behaving as described above.
- Undefined:
  - `true_cnt` is absent from the port list and no counter flops are built.
  - `s` and `s_chg` behaviour is identical in both builds.

## Test plan
- Reset then exhaustive sweep with `mode`=00, applying codes 0..15 one per cycle (`a` = MSB). After each edge, `s`=1 only for codes 4, 8, 9, 12, 13, 14 (6 of 16); all other codes give 0.
- `mode`=01 with code 0101 → `s`=1; code 0110 → `s`=0. `mode`=10 with code 0111 → `s`=1. `mode`=11 with code 1010 → `s`=1, and with code 0010 → `s`=0.
- Latency check: code switches from 0000 to 1100 on a falling edge. `s` must stay 0 until the next rising edge, then read 1. `s_chg`=1 for exactly that one cycle.
- Asynchronous reset mid-operation: with `s`=1, drive `rst_n` low between edges. `s`, `s_chg` and `true_cnt` must read 0 immediately, with no clock edge. After release with code 1000 applied, `s`=1 after one edge.
- With `AB_4_BIT_TRUE_CNT_EN` and `CNT_W`=8, hold code 1100 and `mode`=00 for 300 cycles. `true_cnt` must reach 255 and hold there, and `s_chg` must pulse exactly once.
- Build without the macro: the sweep results above must be identical, and no `true_cnt` port may exist.

Source files
------------

// File: rtl/ab_4_bit.sv
// Registered 2-bit magnitude comparator, A={a,b} vs B={c,d}, relation chosen by mode; AB_4_BIT_TRUE_CNT_EN adds true_cnt.
// Latency: 1 cycle from input sample to s; s_chg pulses in the cycle the new s is first visible.
// Backpressure: none, inputs are evaluated and captured on every rising clk edge.
module ab_4_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic [1:0]       mode,
    output logic             s,
    output logic             s_chg
`ifdef AB_4_BIT_TRUE_CNT_EN
    ,
    output logic [CNT_W-1:0] true_cnt
`endif
);

    logic [1:0] op_a;
    logic [1:0] op_b;
    logic       gt;
    logic       eq;
    logic       lt;
    logic       rel_nxt;

    assign op_a = {a, b};
    assign op_b = {c, d};
    assign gt   = op_a > op_b;
    assign eq   = op_a == op_b;
    assign lt   = op_a < op_b;

    // AND-OR select rather than if/case so an unknown mode or operand stays X
    assign rel_nxt = (~mode[1] & ~mode[0] & gt)
                   | (~mode[1] &  mode[0] & eq)
                   | ( mode[1] & ~mode[0] & lt)
                   | ( mode[1] &  mode[0] & (gt | eq));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s     <= 1'b0;
            s_chg <= 1'b0;
        end else begin
            s     <= rel_nxt;
            s_chg <= rel_nxt ^ s;
        end
    end

`ifdef AB_4_BIT_TRUE_CNT_EN
    logic cnt_inc;

    // Saturating: the increment is masked once every bit is set
    assign cnt_inc = rel_nxt & ~(&true_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            true_cnt <= '0;
        end else begin
            true_cnt <= true_cnt + {{(CNT_W-1){1'b0}}, cnt_inc};
        end
    end
`endif

endmodule

// File: tb/tb_ab_4_bit.sv
// Testbench for ab_4_bit: vector table plus hand-written latency, async-reset and saturation sequences.
module tb_ab_4_bit;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a, b, c, d;
    logic [1:0]       mode;
    logic             s;
    logic             s_chg;
`ifdef AB_4_BIT_TRUE_CNT_EN
    logic [CNT_W-1:0] true_cnt;
`endif

    always #5 clk = ~clk;

    ab_4_bit #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .mode     (mode),
        .s        (s),
        .s_chg    (s_chg)
`ifdef AB_4_BIT_TRUE_CNT_EN
        ,
        .true_cnt (true_cnt)
`endif
    );

    typedef struct {
        logic [3:0] code;
        logic [1:0] md;
        logic       exp_s;
    } vec_t;

    typedef struct packed {
        logic             s;
        logic             chg;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t vecs[23];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic             m_s;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive inputs and push the expected post-edge outputs from the reference model
    task automatic drive(input logic [3:0] code, input logic [1:0] md, input logic exp_s);
        exp_t e;
        {a, b, c, d} = code;
        mode         = md;
        e.s   = exp_s;
        e.chg = exp_s ^ m_s;
        m_s   = exp_s;
        if (exp_s && (m_cnt != {CNT_W{1'b1}}))
            m_cnt = m_cnt + 1'b1;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic sample(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got s=%0b", name, s);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_s"}, {31'b0, s}, {31'b0, e.s});
            chk({name, "_chg"}, {31'b0, s_chg}, {31'b0, e.chg});
`ifdef AB_4_BIT_TRUE_CNT_EN
            chk({name, "_cnt"}, {{(32-CNT_W){1'b0}}, true_cnt}, {{(32-CNT_W){1'b0}}, e.cnt});
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ones;
        int pulses;

        // mode 00 sweep: only 4, 8, 9, 12, 13, 14 give A>B
        for (int i = 0; i < 16; i++) begin
            vecs[i].code  = 4'(i);
            vecs[i].md    = 2'b00;
            vecs[i].exp_s = (i == 4) || (i == 8) || (i == 9) || (i == 12) || (i == 13) || (i == 14);
        end
        vecs[16] = '{4'b0101, 2'b01, 1'b1};
        vecs[17] = '{4'b0110, 2'b01, 1'b0};
        vecs[18] = '{4'b0111, 2'b10, 1'b1};
        vecs[19] = '{4'b1010, 2'b11, 1'b1};
        vecs[20] = '{4'b0010, 2'b11, 1'b0};
        vecs[21] = '{4'b1111, 2'b11, 1'b1};
        vecs[22] = '{4'b1100, 2'b10, 1'b0};

        rst_n = 1'b0;
        {a, b, c, d} = 4'b0000;
        mode  = 2'b00;
        m_s   = 1'b0;
        m_cnt = '0;
        #2;
        chk("reset_s", {31'b0, s}, 32'd0);
        chk("reset_chg", {31'b0, s_chg}, 32'd0);
`ifdef AB_4_BIT_TRUE_CNT_EN
        chk("reset_cnt", {{(32-CNT_W){1'b0}}, true_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        ones = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].code, vecs[i].md, vecs[i].exp_s);
            sample($sformatf("vec%0d", i));
            if (i < 16 && s === 1'b1)
                ones++;
        end
        chk("sweep_ones", ones, 32'd6);

        // Latency: input change on falling edge must not reach s before the rising edge
        @(negedge clk);
        drive(4'b0000, 2'b00, 1'b0);
        sample("lat_pre");
        @(negedge clk);
        drive(4'b1100, 2'b00, 1'b1);
        #1;
        chk("lat_hold", {31'b0, s}, 32'd0);
        sample("lat_edge");
        @(negedge clk);
        drive(4'b1100, 2'b00, 1'b1);
        sample("lat_after");

        // Async reset between edges while s=1
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s", {31'b0, s}, 32'd0);
        chk("arst_chg", {31'b0, s_chg}, 32'd0);
`ifdef AB_4_BIT_TRUE_CNT_EN
        chk("arst_cnt", {{(32-CNT_W){1'b0}}, true_cnt}, 32'd0);
`endif
        m_s   = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        chk("arst_hold_s", {31'b0, s}, 32'd0);
        drive(4'b1000, 2'b00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sample("arst_release");

`ifdef AB_4_BIT_TRUE_CNT_EN
        // Saturation: hold 1100 / mode 00 for 300 cycles from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        m_s   = 1'b0;
        m_cnt = '0;
        drive(4'b1100, 2'b00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0)
                rst_n = 1'b1;
            else
                drive(4'b1100, 2'b00, 1'b1);
            sample($sformatf("sat%0d", i));
            if (s_chg === 1'b1)
                pulses++;
        end
        chk("sat_final_cnt", {{(32-CNT_W){1'b0}}, true_cnt}, 32'd255);
        chk("sat_chg_pulses", pulses, 32'd1);
`else
        pulses = 0;
        ones   = pulses;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
